// File: rtl/pipeline_wb_checker_if.sv
// Writeback checker bus: expected-list load, run control, WB tap, verdict.
// master drives load/control/WB inputs; slave (the checker) drives verdict.
interface pipeline_wb_checker_if #(
  parameter int DATA_W  = 32,
  parameter int IDX_W   = 3,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 30
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic              exp_wr_en;
  logic [IDX_W-1:0]  exp_wr_dst;
  logic [DATA_W-1:0] exp_wr_data;
  logic              start;
  logic              clear;
  logic              wb_valid;
  logic [IDX_W-1:0]  wb_dst_idx;
  logic [DATA_W-1:0] wb_result;
  logic              done;
  logic              pass;
  logic              fail;
  logic [1:0]        fail_code;
  logic [DATA_W-1:0] fail_data;
  logic [CW-1:0]     match_count;
  logic [TW-1:0]     cycle_count;
  logic              overflow;

  modport master (
    output exp_wr_en, exp_wr_dst, exp_wr_data,
    output start, clear,
    output wb_valid, wb_dst_idx, wb_result,
    input  done, pass, fail, fail_code, fail_data,
    input  match_count, cycle_count, overflow
  );

  modport slave (
    input  exp_wr_en, exp_wr_dst, exp_wr_data,
    input  start, clear,
    input  wb_valid, wb_dst_idx, wb_result,
    output done, pass, fail, fail_code, fail_data,
    output match_count, cycle_count, overflow
  );
endinterface

// File: rtl/pipeline_wb_checker.sv
// WB-stream checker: retired writes vs preloaded (dst,value) list -> PASS/FAIL.
// Ports: clk, rst (async high), bus (slave: load/start/clear/WB in, verdict out).
module pipeline_wb_checker #(
  parameter int DATA_W  = 32,
  parameter int IDX_W   = 3,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 30,
  parameter logic [DATA_W-1:0] TRAP_VALUE = DATA_W'(32'hFADEDACE)
) (
  input  logic clk,
  input  logic rst,
  pipeline_wb_checker_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL  = CW'(DEPTH);
  localparam logic [PW-1:0] LAST  = PW'(DEPTH - 1);
  localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

  state_t            r_state;
  logic [IDX_W-1:0]  r_dst [DEPTH];
  logic [DATA_W-1:0] r_val [DEPTH];
  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [CW-1:0]     r_cnt;
  logic              r_done;
  logic              r_pass;
  logic              r_fail;
  logic [1:0]        r_code;
  logic [DATA_W-1:0] r_fdata;
  logic [CW-1:0]     r_mcnt;
  logic [TW-1:0]     r_ccnt;
  logic              r_ovf;

  logic          w_push;
  logic          w_trap;
  logic          w_hit;
  logic          w_miss;
  logic          w_last;
  logic          w_tout;
  logic [PW-1:0] w_head_nxt;
  logic [PW-1:0] w_tail_nxt;

  assign w_push = (r_state == S_IDLE) && !bus.clear
                && bus.exp_wr_en && (r_cnt != FULL);
  assign w_trap = bus.wb_valid && (bus.wb_result == TRAP_VALUE);
  assign w_hit  = bus.wb_valid
                && (bus.wb_dst_idx == r_dst[r_head])
                && (bus.wb_result == r_val[r_head]);
  assign w_miss = bus.wb_valid && !w_hit;
  assign w_last = (r_cnt == CW'(1));
  assign w_tout = (r_ccnt >= TLAST);

  assign w_head_nxt = (r_head == LAST) ? '0 : r_head + 1'b1;
  assign w_tail_nxt = (r_tail == LAST) ? '0 : r_tail + 1'b1;

  // List storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_dst[r_tail] <= bus.exp_wr_dst;
      r_val[r_tail] <= bus.exp_wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_head  <= '0;
      r_tail  <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_fail  <= 1'b0;
      r_code  <= 2'd0;
      r_fdata <= '0;
      r_mcnt  <= '0;
      r_ccnt  <= '0;
      r_ovf   <= 1'b0;
    end else if (bus.clear) begin
      r_state <= S_IDLE;
      r_head  <= '0;
      r_tail  <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_fail  <= 1'b0;
      r_code  <= 2'd0;
      r_fdata <= '0;
      r_mcnt  <= '0;
      r_ccnt  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_push) begin
            r_tail <= w_tail_nxt;
            r_cnt  <= r_cnt + 1'b1;
          end else if (bus.exp_wr_en) begin
            r_ovf  <= 1'b1;
          end
          if (bus.start) begin
            r_state <= S_RUN;
            r_ccnt  <= '0;
          end
        end
        S_RUN: begin
          if (r_ccnt != TMAX) r_ccnt <= r_ccnt + 1'b1;
          if (r_cnt == '0) begin
            r_state <= S_PASS;
            r_done  <= 1'b1;
            r_pass  <= 1'b1;
          end else if (w_trap) begin
            r_state <= S_FAIL;
            r_done  <= 1'b1;
            r_fail  <= 1'b1;
            r_code  <= 2'd1;
            r_fdata <= bus.wb_result;
          end else if (w_miss) begin
            r_state <= S_FAIL;
            r_done  <= 1'b1;
            r_fail  <= 1'b1;
            r_code  <= 2'd2;
            r_fdata <= bus.wb_result;
          end else begin
            if (w_hit) begin
              r_head <= w_head_nxt;
              r_cnt  <= r_cnt - 1'b1;
              r_mcnt <= r_mcnt + 1'b1;
            end
            // The final match wins over a timeout in the same cycle.
            if (w_hit && w_last) begin
              r_state <= S_PASS;
              r_done  <= 1'b1;
              r_pass  <= 1'b1;
            end else if (w_tout) begin
              r_state <= S_FAIL;
              r_done  <= 1'b1;
              r_fail  <= 1'b1;
              r_code  <= 2'd3;
              r_fdata <= '0;
            end
          end
        end
        S_PASS: r_state <= S_PASS;
        S_FAIL: r_state <= S_FAIL;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.done        = r_done;
  assign bus.pass        = r_pass;
  assign bus.fail        = r_fail;
  assign bus.fail_code   = r_code;
  assign bus.fail_data   = r_fdata;
  assign bus.match_count = r_mcnt;
  assign bus.cycle_count = r_ccnt;
  assign bus.overflow    = r_ovf;
endmodule

// File: tb/tb_pipeline_wb_checker.sv
// Bench for pipeline_wb_checker: directed table, corner sequences, random vs queue model.
// Drives the bus master side; samples outputs 1 ns after each rising edge.
module tb_pipeline_wb_checker;
  localparam int DEPTH = 8;
  localparam int TO    = 30;
  localparam logic [31:0] TRAP = 32'hFADEDACE;
  localparam logic [31:0] A    = 32'h12341235;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipeline_wb_checker_if #(
    .DATA_W(32), .IDX_W(3), .DEPTH(DEPTH), .TIMEOUT(TO)
  ) bus ();

  pipeline_wb_checker #(
    .DATA_W(32), .IDX_W(3), .DEPTH(DEPTH), .TIMEOUT(TO),
    .TRAP_VALUE(TRAP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_vec = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [2:0]  d;
    logic [31:0] v;
  } ent_t;

  ent_t        m_q[$];
  int          m_st;
  int          m_code;
  logic [31:0] m_fd;
  int          m_mc;
  int          m_cc;
  bit          m_ovf;

  typedef struct {
    logic        clr, we;
    logic [2:0]  wd;
    logic [31:0] wdat;
    logic        st, v;
    logic [2:0]  vd;
    logic [31:0] vr;
    logic        dn, ps, fl;
    logic [1:0]  fc;
    logic [31:0] fd;
    logic [3:0]  mc;
    logic [4:0]  cc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int clr, int we, int wd, int wdat,
                              int st, int v, int vd, int vr,
                              int dn, int ps, int fl, int fc,
                              int fd, int mc, int cc);
    vec_t r;
    r.clr = clr[0]; r.we = we[0]; r.wd = wd[2:0]; r.wdat = wdat;
    r.st = st[0]; r.v = v[0]; r.vd = vd[2:0]; r.vr = vr;
    r.dn = dn[0]; r.ps = ps[0]; r.fl = fl[0]; r.fc = fc[1:0];
    r.fd = fd; r.mc = mc[3:0]; r.cc = cc[4:0];
    return r;
  endfunction

  function automatic logic [46:0] act();
    return {bus.done, bus.pass, bus.fail, bus.fail_code,
            bus.fail_data, bus.match_count, bus.cycle_count,
            bus.overflow};
  endfunction

  function automatic logic [46:0] mexp();
    return {m_st >= 2, m_st == 2, m_st == 3, m_code[1:0],
            m_fd, m_mc[3:0], m_cc[4:0], m_ovf};
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_st = 0; m_code = 0; m_fd = '0;
    m_mc = 0; m_cc = 0; m_ovf = 1'b0;
  endtask

  task automatic m_fail(int code, logic [31:0] fd);
    m_st = 3; m_code = code; m_fd = fd;
  endtask

  // Queue model: one call per clock with the inputs of that clock.
  task automatic model_step(int clr, int we, int wd, int wdat,
                            int st, int v, int vd, int vr);
    int   old;
    ent_t e;
    if (clr[0]) begin
      model_reset();
      return;
    end
    case (m_st)
      0: begin
        if (we[0]) begin
          if (m_q.size() < DEPTH) begin
            e.d = wd[2:0]; e.v = wdat;
            m_q.push_back(e);
          end else m_ovf = 1'b1;
        end
        if (st[0]) begin m_st = 1; m_cc = 0; end
      end
      1: begin
        old = m_cc;
        if (m_cc < TO) m_cc++;
        if (m_q.size() == 0) m_st = 2;
        else if (v[0] && vr == TRAP) m_fail(1, vr);
        else if (v[0] && (vd[2:0] != m_q[0].d || vr != m_q[0].v))
          m_fail(2, vr);
        else begin
          if (v[0]) begin
            void'(m_q.pop_front());
            m_mc++;
          end
          if (v[0] && m_q.size() == 0) m_st = 2;
          else if (old == TO - 1) m_fail(3, '0);
        end
      end
      default: ;
    endcase
  endtask

  task automatic drv(int clr, int we, int wd, int wdat,
                     int st, int v, int vd, int vr);
    bus.clear       = clr[0];
    bus.exp_wr_en   = we[0];
    bus.exp_wr_dst  = wd[2:0];
    bus.exp_wr_data = wdat;
    bus.start       = st[0];
    bus.wb_valid    = v[0];
    bus.wb_dst_idx  = vd[2:0];
    bus.wb_result   = vr;
  endtask

  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  task automatic chk_model(string nm);
    n_vec++;
    if (act() !== mexp()) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act(), mexp());
    end
  endtask

  task automatic cyc(string nm, int clr, int we, int wd, int wdat,
                     int st, int v, int vd, int vr);
    drv(clr, we, wd, wdat, st, v, vd, vr);
    model_step(clr, we, wd, wdat, st, v, vd, vr);
    @(posedge clk);
    #1;
    chk_model(nm);
  endtask

  task automatic c_clr();          cyc("clear", 1, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic c_idle();         cyc("idle",  0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic c_go();           cyc("start", 0, 0, 0, 0, 1, 0, 0, 0); endtask
  task automatic c_push(int d, int x); cyc("push", 0, 1, d, x, 0, 0, 0, 0); endtask
  task automatic c_wb(int d, int x);   cyc("wb",   0, 0, 0, 0, 0, 1, d, x); endtask

  function automatic int rnd_data();
    int x;
    x = $urandom;
    if (x == TRAP) x = x ^ 1;
    return x;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   k;
    int   dv [9];
    vec_t r;

    drv(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();

    //           clr we wd wdat st v vd vr     dn ps fl fc fd  mc cc
    tbl.push_back(mk(1,0,0,0,    0,0,0,0,     0,0,0,0,0,    0,0));
    tbl.push_back(mk(0,1,0,A,    0,0,0,0,     0,0,0,0,0,    0,0));
    tbl.push_back(mk(0,0,0,0,    1,0,0,0,     0,0,0,0,0,    0,0));
    tbl.push_back(mk(0,0,0,0,    0,1,0,TRAP,  1,0,1,1,TRAP, 0,1));
    tbl.push_back(mk(1,0,0,0,    0,0,0,0,     0,0,0,0,0,    0,0));
    tbl.push_back(mk(0,1,0,TRAP, 0,0,0,0,     0,0,0,0,0,    0,0));
    tbl.push_back(mk(0,0,0,0,    1,0,0,0,     0,0,0,0,0,    0,0));
    tbl.push_back(mk(0,0,0,0,    0,1,0,TRAP,  1,0,1,1,TRAP, 0,1));
    tbl.push_back(mk(1,0,0,0,    0,0,0,0,     0,0,0,0,0,    0,0));
    tbl.push_back(mk(0,1,1,1,    0,0,0,0,     0,0,0,0,0,    0,0));
    tbl.push_back(mk(0,1,2,2,    0,0,0,0,     0,0,0,0,0,    0,0));
    tbl.push_back(mk(0,1,3,3,    0,0,0,0,     0,0,0,0,0,    0,0));
    tbl.push_back(mk(0,0,0,0,    1,0,0,0,     0,0,0,0,0,    0,0));
    tbl.push_back(mk(0,0,0,0,    0,1,1,1,     0,0,0,0,0,    1,1));
    tbl.push_back(mk(0,0,0,0,    0,1,2,5,     1,0,1,2,5,    1,2));
    tbl.push_back(mk(1,0,0,0,    0,0,0,0,     0,0,0,0,0,    0,0));
    tbl.push_back(mk(0,0,0,0,    1,0,0,0,     0,0,0,0,0,    0,0));
    tbl.push_back(mk(0,0,0,0,    0,0,0,0,     1,1,0,0,0,    0,1));
    tbl.push_back(mk(1,0,0,0,    0,0,0,0,     0,0,0,0,0,    0,0));
    tbl.push_back(mk(0,1,0,A,    0,0,0,0,     0,0,0,0,0,    0,0));
    tbl.push_back(mk(0,0,0,0,    1,0,0,0,     0,0,0,0,0,    0,0));
    tbl.push_back(mk(0,0,0,0,    0,0,0,0,     0,0,0,0,0,    0,1));
    tbl.push_back(mk(0,0,0,0,    0,0,0,0,     0,0,0,0,0,    0,2));
    tbl.push_back(mk(0,0,0,0,    0,0,0,0,     0,0,0,0,0,    0,3));
    tbl.push_back(mk(0,0,0,0,    0,0,0,0,     0,0,0,0,0,    0,4));
    tbl.push_back(mk(0,0,0,0,    0,1,0,A,     1,1,0,0,0,    1,5));

    // Reset values
    @(posedge clk);
    #1;
    chk("reset_state", act() == '0, 1);
    rst = 1'b0;

    // Directed table
    foreach (tbl[i]) begin
      r = tbl[i];
      drv(r.clr, r.we, r.wd, r.wdat, r.st, r.v, r.vd, r.vr);
      model_step(r.clr, r.we, r.wd, r.wdat, r.st, r.v, r.vd, r.vr);
      @(posedge clk);
      #1;
      n_vec++;
      if (act() !== {r.dn, r.ps, r.fl, r.fc, r.fd, r.mc, r.cc, 1'b0}) begin
        n_bad++;
        $display("FAIL table[%0d]: got %h want %h", i, act(),
                 {r.dn, r.ps, r.fl, r.fc, r.fd, r.mc, r.cc, 1'b0});
      end
    end

    // Timeout with no WB traffic
    c_clr();
    c_push(5, 32'h0BADF00D);
    c_go();
    k = 0;
    for (int j = 1; j <= 40; j++) begin
      c_idle();
      if (bus.done) begin
        k = j;
        break;
      end
    end
    chk("timeout_code", bus.fail_code, 3);
    chk("timeout_edges", k, 30);
    chk("timeout_cc", bus.cycle_count, 30);
    chk("timeout_fdata", bus.fail_data, 0);

    // Final match on the timeout cycle wins
    c_clr();
    c_push(5, 32'h0BADF00D);
    c_go();
    for (int j = 0; j < 29; j++) c_idle();
    c_wb(5, 32'h0BADF00D);
    chk("late_match_pass", bus.pass, 1);
    chk("late_match_cc", bus.cycle_count, 30);

    // Overflow, then pointer wrap over two fills
    for (int pass_n = 0; pass_n < 2; pass_n++) begin
      c_clr();
      chk("clear_ovf", bus.overflow, 0);
      for (int j = 0; j < 9; j++) begin
        dv[j] = rnd_data();
        c_push(j % 8, dv[j]);
      end
      chk("overflow", bus.overflow, 1);
      c_go();
      for (int j = 0; j < 8; j++) c_wb(j, dv[j]);
      chk("full_pass", bus.pass, 1);
      chk("full_mc", bus.match_count, 8);
    end

    // Async reset in the middle of RUN
    c_clr();
    c_push(1, 11);
    c_push(2, 22);
    c_push(3, 33);
    c_go();
    c_wb(1, 11);
    c_wb(2, 22);
    chk("pre_rst_mc", bus.match_count, 2);
    #3 rst = 1'b1;
    #1 chk("async_rst", act() == '0, 1);
    #1 rst = 1'b0;
    model_reset();
    c_idle();

    // Clear out of FAIL, then an empty-list run
    c_clr();
    for (int j = 0; j < 9; j++) c_push(j % 8, j);
    c_go();
    c_wb(7, 0);
    chk("fail_mismatch", bus.fail_code, 2);
    c_clr();
    chk("clear_in_fail_ovf", bus.overflow, 0);
    chk("clear_in_fail_done", bus.done, 0);
    c_go();
    c_idle();
    chk("empty_pass", bus.pass, 1);

    // Random traffic against the queue model
    c_clr();
    for (int i = 0; i < 500; i++) begin
      int c, we, wd, wx, st, v, vd, vr, p;
      c = 0; we = 0; wd = 0; wx = 0; st = 0; v = 0; vd = 0; vr = 0;
      c = ($urandom_range(0, 99) < 2);
      case (m_st)
        0: begin
          we = ($urandom_range(0, 99) < 50);
          wd = $urandom_range(0, 7);
          wx = ($urandom_range(0, 9) == 0) ? TRAP : rnd_data();
          st = ($urandom_range(0, 99) < 15);
        end
        1: begin
          if (m_q.size() > 0 && $urandom_range(0, 99) < 40) begin
            p  = $urandom_range(0, 99);
            v  = 1;
            vd = m_q[0].d;
            vr = m_q[0].v;
            if (p >= 90) vr = TRAP;
            else if (p >= 80) vd = (vd + 1) % 8;
          end
        end
        default: begin
          v  = $urandom_range(0, 1);
          vd = $urandom_range(0, 7);
          vr = rnd_data();
          c  = ($urandom_range(0, 99) < 25);
        end
      endcase
      cyc("random", c, we, wd, wx, st, v, vd, vr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/pipeline_wb_checker.md
# pipeline_wb_checker

Synthesizable, parametrised writeback-stream checker for the pipelined core. It sits beside `pipeline_top` in simulation and FPGA bring-up, sampling the WB stage's valid/destination/result signals. It compares every retired register write, in order, against a preloaded list of expected (destination, value) pairs. It reports PASS, or FAIL with a cause code: trap value retired, mismatch, or timeout. This replaces per-bench ad-hoc trap, success and timeout checks with one reusable block that has a deterministic verdict.

## Interface
- `DATA_W`, 32, width of WB result and expected values
- `IDX_W`, 3, width of register destination index
- `DEPTH`, 8, number of expected entries held (≥1)
- `TIMEOUT`, 30, observation window in RUN cycles (≥1)
- `TRAP_VALUE`, 32'hFADEDACE, any retired result equal to this is a fatal trap
- `clk` in 1 — single clock, rising edge
- `rst` in 1 — asynchronous, active-high reset
- `exp_wr_en` in 1 — push one expected entry (accepted only in IDLE)
- `exp_wr_dst` in IDX_W — expected destination index
- `exp_wr_data` in DATA_W — expected result value
- `start` in 1 — IDLE→RUN
- `clear` in 1 — any state→IDLE, empties list, zeroes counters and flags
- `wb_valid` in 1 — WB stage valid
- `wb_dst_idx` in IDX_W — WB destination
- `wb_result` in DATA_W — WB data
- `done` out 1 — verdict reached (PASS or FAIL state)
- `pass` out 1 — PASS state
- `fail` out 1 — FAIL state
- `fail_code` out 2 — 0 none, 1 trap, 2 mismatch, 3 timeout
- `fail_data` out DATA_W — wb_result that caused trap/mismatch; 0 on timeout
- `match_count` out $clog2(DEPTH+1) — entries matched so far
- `cycle_count` out $clog2(TIMEOUT+1) — RUN cycles elapsed, saturating
- `overflow` out 1 — sticky: push attempted while list full

## Operation
- FSM states: IDLE, RUN, PASS, FAIL. Reset and `clear` → IDLE. `clear` has priority over every other input.
- IDLE: `exp_wr_en` appends at tail if count<DEPTH; if full, entry dropped, `overflow`←1. `start` → RUN. A push in the same cycle as `start` is accepted first.
- IDLE with `exp_wr_en` in RUN/PASS/FAIL: ignored, no overflow.
- RUN, evaluated each cycle in priority order:
  1. `wb_valid` && `wb_result`==TRAP_VALUE → FAIL, code 1, fail_data←wb_result. Applies even if the result also matches head.
  2. `wb_valid` && (dst≠head.dst || result≠head.data) → FAIL, code 2, fail_data←wb_result.
  3. `wb_valid` && match → pop head, match_count+1. If list becomes empty → PASS.
  4. Otherwise, if cycle_count==TIMEOUT-1 → FAIL, code 3. A final match in this same cycle gives PASS, not timeout.
- `wb_valid` with list empty in RUN cannot occur. Empty list at `start` → RUN → PASS on the first RUN cycle without consuming WB.
- cycle_count: 0 on entry to RUN, +1 each RUN cycle, saturates at TIMEOUT, frozen in PASS/FAIL.
- PASS/FAIL are terminal until `clear` or `rst`. WB activity is ignored there.
- List is a circular buffer. Head/tail pointers wrap modulo DEPTH; occupancy counter distinguishes full from empty.

## Timing
- All outputs registered. Reset values: done=0, pass=0, fail=0, fail_code=0, fail_data=0, match_count=0, cycle_count=0, overflow=0, list empty, state IDLE.
- WB sample at edge N → verdict or match_count visible after edge N (1-cycle latency), readable at N+#1.
- `start` sampled at edge N → first RUN sample at edge N+1.
- Timeout verdict registers at the TIMEOUT-th RUN edge.
- `rst` asserted mid-RUN clears immediately (async) regardless of clk. Deassertion is synchronous to the next edge.

## Test plan
- Load (dst 0, 32'h12341235), start. WB valid at 5th RUN cycle with dst 0, 32'h12341235 → pass=1, done=1, match_count=1, cycle_count=5, fail_code=0.
- Load (0, 32'h12341235), start. WB dst 0 result 32'hFADEDACE → fail=1, fail_code=1, fail_data=FADEDACE, match_count=0. Repeat with expected value FADEDACE: still code 1.
- Load three entries (1,1),(2,2),(3,3). WB (1,1) then (2,5) → fail_code=2, fail_data=5, match_count=1.
- TIMEOUT=30, load one entry, start, no wb_valid → fail_code=3 exactly 30 RUN cycles after start, cycle_count=30. Last entry matched on 30th cycle → pass instead.
- DEPTH=8: push 9 entries → overflow=1, 9th dropped. Feed the 8 matching WBs → pass, match_count=8. Pointer wrap: clear, reload 8, pass again.
- Assert rst for 2 ns mid-RUN (match_count=2) → all outputs 0 asynchronously. Assert clear in FAIL → IDLE, overflow=0, list empty, next start with empty list → pass.
